// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 lines of 4 bytes in front of a
// block-wide memory, stalling the CPU through o_busywait while a line is evicted or filled.
module data_cache #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int ADDR_W   = 8
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_read,
  input  logic                                    i_write,
  input  logic [ADDR_W-1:0]                       i_address,
  input  logic [7:0]                              i_writedata,
  output logic [7:0]                              o_readdata,
  output logic                                    o_busywait,
  output logic                                    o_mem_read,
  output logic                                    o_mem_write,
  output logic [ADDR_W-OFFSET_W-1:0]              o_mem_address,
  output logic [31:0]                             o_mem_writedata,
  input  logic [31:0]                             i_mem_readdata,
  input  logic                                    i_mem_busywait
);

  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_entry;
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES];

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [31:0]         w_line;
  logic                w_hit;
  logic                w_req;
  logic                w_done;

  assign w_tag      = i_address[ADDR_W-1 -: TAG_W];
  assign w_index    = i_address[OFFSET_W +: INDEX_W];
  assign w_offset   = i_address[OFFSET_W-1:0];
  assign w_line     = r_data[w_index];
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_req      = i_read || i_write;
  assign o_readdata = w_line[{w_offset, 3'b000} +: 8];
  assign o_busywait = !i_reset && ((r_state != IDLE) || (w_req && !w_hit));
  // The cycle right after entering a memory state ignores i_mem_busywait, because the
  // memory has not yet seen the new request.
  assign w_done     = !r_entry && !i_mem_busywait;

  always_comb begin
    w_next          = r_state;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_address   = {w_tag, w_index};
    o_mem_writedata = '0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          w_next = (r_valid[w_index] && r_dirty[w_index]) ? WRITE_BACK : FETCH;
        end
      end
      WRITE_BACK: begin
        o_mem_write     = 1'b1;
        o_mem_address   = {r_tag[w_index], w_index};
        o_mem_writedata = w_line;
        if (w_done) w_next = FETCH;
      end
      FETCH: begin
        o_mem_read = 1'b1;
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Data and tags need no reset; clearing valid/dirty drops the whole cache, including
  // any half-finished fill.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_entry <= 1'b0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
      if ((r_state == FETCH) && w_done) begin
        r_data[w_index]  <= i_mem_readdata;
        r_tag[w_index]   <= w_tag;
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if ((r_state == IDLE) && i_write && w_hit) begin
        r_data[w_index][{w_offset, 3'b000} +: 8] <= i_writedata;
        r_dirty[w_index] <= 1'b1;
      end
    end
  end

endmodule
